// File: rtl/state_machine_pkg.sv
// Shared definitions for the control-unit sequencer and the datapath that
// decodes its state output: field widths, state codes and opcode values.
package state_machine_pkg;

  localparam int STATE_W = 6;
  localparam int OP_W    = 6;

  // Control state codes (18..63 are unused and recover to IDLE)
  localparam logic [STATE_W-1:0] ST_IDLE   = 6'd0;
  localparam logic [STATE_W-1:0] ST_FETCH1 = 6'd1;
  localparam logic [STATE_W-1:0] ST_FETCH2 = 6'd2;
  localparam logic [STATE_W-1:0] ST_FETCH3 = 6'd3;
  localparam logic [STATE_W-1:0] ST_DECODE = 6'd4;
  localparam logic [STATE_W-1:0] ST_LOAD1  = 6'd5;
  localparam logic [STATE_W-1:0] ST_LOAD2  = 6'd6;
  localparam logic [STATE_W-1:0] ST_LOAD3  = 6'd7;
  localparam logic [STATE_W-1:0] ST_STORE1 = 6'd8;
  localparam logic [STATE_W-1:0] ST_STORE2 = 6'd9;
  localparam logic [STATE_W-1:0] ST_MOV1   = 6'd10;
  localparam logic [STATE_W-1:0] ST_ADD1   = 6'd11;
  localparam logic [STATE_W-1:0] ST_ADD2   = 6'd12;
  localparam logic [STATE_W-1:0] ST_SUB1   = 6'd13;
  localparam logic [STATE_W-1:0] ST_SUB2   = 6'd14;
  localparam logic [STATE_W-1:0] ST_JUMP1  = 6'd15;
  localparam logic [STATE_W-1:0] ST_JUMP2  = 6'd16;
  localparam logic [STATE_W-1:0] ST_HALT1  = 6'd17;

  // Opcodes held in IR[15:10]; 8..63 are illegal and execute as NOP
  localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
  localparam logic [OP_W-1:0] OP_LOAD  = 6'd1;
  localparam logic [OP_W-1:0] OP_STORE = 6'd2;
  localparam logic [OP_W-1:0] OP_MOV   = 6'd3;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd4;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd5;
  localparam logic [OP_W-1:0] OP_JUMP  = 6'd6;
  localparam logic [OP_W-1:0] OP_HALT  = 6'd7;

endpackage

// File: rtl/state_machine.sv
// Control-unit sequencer of the 16-bit multi-cycle processor.
// Walks fetch / decode / per-opcode execute steps and presents the
// registered state code to the datapath.
// Optional feature: define STATE_MACHINE_HALT_EN to make opcode 7 stop the
// machine (DECODE -> HALT1 -> IDLE). Without it opcode 7 runs as a NOP and
// only reset leaves the run loop.
module state_machine
  import state_machine_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        IR,
  output logic [STATE_W-1:0] state
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [OP_W-1:0]    opcode;
  logic               ir_unused;

  assign opcode    = IR[15:10];
  // Operand fields belong to the datapath; the sequencer only needs the opcode
  assign ir_unused = ^IR[9:0];

  // State register: synchronous reset dominates every transition
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IR is only consulted in DECODE, start only in IDLE
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:   state_d = start ? ST_FETCH1 : ST_IDLE;
      ST_FETCH1: state_d = ST_FETCH2;
      ST_FETCH2: state_d = ST_FETCH3;
      ST_FETCH3: state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_NOP:   state_d = ST_FETCH1;
          OP_LOAD:  state_d = ST_LOAD1;
          OP_STORE: state_d = ST_STORE1;
          OP_MOV:   state_d = ST_MOV1;
          OP_ADD:   state_d = ST_ADD1;
          OP_SUB:   state_d = ST_SUB1;
          OP_JUMP:  state_d = ST_JUMP1;
`ifdef STATE_MACHINE_HALT_EN
          OP_HALT:  state_d = ST_HALT1;
`endif
          // Illegal opcodes behave as NOP
          default:  state_d = ST_FETCH1;
        endcase
      end
      ST_LOAD1:  state_d = ST_LOAD2;
      ST_LOAD2:  state_d = ST_LOAD3;
      ST_LOAD3:  state_d = ST_FETCH1;
      ST_STORE1: state_d = ST_STORE2;
      ST_STORE2: state_d = ST_FETCH1;
      ST_MOV1:   state_d = ST_FETCH1;
      ST_ADD1:   state_d = ST_ADD2;
      ST_ADD2:   state_d = ST_FETCH1;
      ST_SUB1:   state_d = ST_SUB2;
      ST_SUB2:   state_d = ST_FETCH1;
      ST_JUMP1:  state_d = ST_JUMP2;
      ST_JUMP2:  state_d = ST_FETCH1;
`ifdef STATE_MACHINE_HALT_EN
      ST_HALT1:  state_d = ST_IDLE;
`endif
      // Unused codes (and HALT1 when halting is not built) fall back to IDLE
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output logic: the datapath sees the state register directly
  always_comb begin
    state = state_q;
  end

endmodule

// File: tb/tb_state_machine.sv
// Self-checking bench for state_machine: a table of
// {reset, start, opcode, expected state} vectors applied one clock each,
// followed by a hand-written sequence where IR changes outside DECODE.
// Honours STATE_MACHINE_HALT_EN when choosing the HALT expectations.
module tb_state_machine;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] IR;
  logic [5:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       rst;
    logic       go;
    logic [5:0] op;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  state_machine dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .IR    (IR),
    .state (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic add_vec(input logic r, input logic g, input logic [5:0] op,
                         input logic [5:0] e);
    vec_t v;
    v.rst = r;
    v.go  = g;
    v.op  = op;
    v.exp = e;
    vecs.push_back(v);
  endtask

  // Standard fetch + decode prefix, all with the same inputs
  task automatic add_fetch(input logic g, input logic [5:0] op);
    add_vec(1'b0, g, op, 6'd1);
    add_vec(1'b0, g, op, 6'd2);
    add_vec(1'b0, g, op, 6'd3);
    add_vec(1'b0, g, op, 6'd4);
  endtask

  task automatic check(input string name, input logic [5:0] exp);
    n_checks++;
    if (state === exp) begin
      n_pass++;
      $display("%s: state=%0d expected=%0d ok", name, state, exp);
    end else begin
      $display("FAIL %s: state=%0d expected=%0d", name, state, exp);
    end
  endtask

  // One clock edge with the given inputs, then sample away from the edge
  task automatic step(input logic r, input logic g, input logic [5:0] op,
                      input string name, input logic [5:0] exp);
    reset = r;
    start = g;
    IR    = {op, 10'h2A5};
    @(posedge clock);
    #1;
    check(name, exp);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    IR    = 16'h0000;

    // Reset, including with start and a LOAD opcode present
    add_vec(1'b1, 1'b1, 6'd1, 6'd0);
    add_vec(1'b1, 1'b0, 6'd0, 6'd0);
    // Idle with start low: stays in IDLE regardless of IR
    for (int i = 0; i < 10; i++) add_vec(1'b0, 1'b0, 6'd1, 6'd0);
    // LOAD repeating with a 7-cycle period
    for (int k = 0; k < 2; k++) begin
      add_fetch(1'b1, 6'd1);
      add_vec(1'b0, 1'b1, 6'd1, 6'd5);
      add_vec(1'b0, 1'b1, 6'd1, 6'd6);
      add_vec(1'b0, 1'b1, 6'd1, 6'd7);
    end
    // STORE
    add_fetch(1'b1, 6'd2);
    add_vec(1'b0, 1'b1, 6'd2, 6'd8);
    add_vec(1'b0, 1'b1, 6'd2, 6'd9);
    // MOV
    add_fetch(1'b1, 6'd3);
    add_vec(1'b0, 1'b1, 6'd3, 6'd10);
    // ADD
    add_fetch(1'b1, 6'd4);
    add_vec(1'b0, 1'b1, 6'd4, 6'd11);
    add_vec(1'b0, 1'b1, 6'd4, 6'd12);
    // SUB
    add_fetch(1'b1, 6'd5);
    add_vec(1'b0, 1'b1, 6'd5, 6'd13);
    add_vec(1'b0, 1'b1, 6'd5, 6'd14);
    // JUMP
    add_fetch(1'b1, 6'd6);
    add_vec(1'b0, 1'b1, 6'd6, 6'd15);
    add_vec(1'b0, 1'b1, 6'd6, 6'd16);
    // NOP and illegal opcodes 8 and 63: DECODE straight back to FETCH1
    add_fetch(1'b1, 6'd0);
    add_fetch(1'b1, 6'd8);
    add_fetch(1'b1, 6'd63);
    // HALT
    add_fetch(1'b1, 6'd7);
`ifdef STATE_MACHINE_HALT_EN
    add_vec(1'b0, 1'b1, 6'd7, 6'd17);
    add_vec(1'b0, 1'b1, 6'd7, 6'd0);
    add_vec(1'b0, 1'b1, 6'd7, 6'd1);
`else
    add_vec(1'b0, 1'b1, 6'd7, 6'd1);
`endif
    // start dropped mid-LOAD: program keeps running
    add_vec(1'b0, 1'b0, 6'd1, 6'd2);
    add_vec(1'b0, 1'b0, 6'd1, 6'd3);
    add_vec(1'b0, 1'b0, 6'd1, 6'd4);
    add_vec(1'b0, 1'b0, 6'd1, 6'd5);
    add_vec(1'b0, 1'b0, 6'd1, 6'd6);
    add_vec(1'b0, 1'b0, 6'd1, 6'd7);
    add_vec(1'b0, 1'b0, 6'd1, 6'd1);
    add_vec(1'b0, 1'b0, 6'd1, 6'd2);
    add_vec(1'b0, 1'b0, 6'd1, 6'd3);
    add_vec(1'b0, 1'b0, 6'd1, 6'd4);
    add_vec(1'b0, 1'b0, 6'd1, 6'd5);
    add_vec(1'b0, 1'b0, 6'd1, 6'd6);
    // Reset while in LOAD2 aborts the instruction
    add_vec(1'b1, 1'b1, 6'd1, 6'd0);
    add_vec(1'b0, 1'b0, 6'd1, 6'd0);
    add_vec(1'b0, 1'b0, 6'd1, 6'd0);
    add_vec(1'b0, 1'b1, 6'd1, 6'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].go, vecs[i].op,
           $sformatf("vec%0d", i), vecs[i].exp);
    end

    // IR only matters in DECODE: from FETCH1, garbage opcodes elsewhere,
    // SUB presented exactly while in DECODE
    step(1'b0, 1'b0, 6'd1,  "ir_f1",  6'd2);
    step(1'b0, 1'b0, 6'd6,  "ir_f2",  6'd3);
    step(1'b0, 1'b0, 6'd2,  "ir_f3",  6'd4);
    step(1'b0, 1'b0, 6'd5,  "ir_dec", 6'd13);
    step(1'b0, 1'b0, 6'd1,  "ir_x1",  6'd14);
    step(1'b0, 1'b0, 6'd3,  "ir_x2",  6'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
